// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential 2x2 matrix multiplier: default widths,
// accumulator width rule and the controller state encoding.
package matmul_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF  = 16;
  localparam int ACC_W_DEF  = OUT_W_DEF + 1;

  // One guard bit above the result width: two DATA_W*DATA_W products never wrap.
  function automatic int acc_w(input int out_w);
    return out_w + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/matmul_mac.sv
// Single signed multiply-accumulate unit shared by all eight products of a run.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    base;

  assign prod     = a_i * b_i;
  assign prod_ext = ACC_W'(prod);
  // Clearing selects zero as the addend so the first product of an element starts fresh.
  assign base     = clr_i ? '0 : acc_q;
  assign sum_o    = base + prod_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/matmul_2x2_seq.sv
// Sequential 2x2 signed matrix multiply C = A*B on one time-shared MAC, 8 CALC cycles per run.
// Build option: define MATMUL_SAT_EN to clamp out-of-range elements instead of wrapping.
module matmul_2x2_seq
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DATA_W-1:0]   a_in,
  input  logic [4*DATA_W-1:0]   b_in,
  output logic [4*OUT_W-1:0]    c_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int ACC_W = acc_w(OUT_W);

  state_e                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [4*DATA_W-1:0]     a_q, b_q;
  logic [OUT_W-1:0]        shadow_q [4];
  logic [4*OUT_W-1:0]      c_q;
  logic                    ovf_q;
  logic                    accept, mac_en, mac_clr, elem_wr;
  logic [1:0]              a_idx, b_idx, c_idx;
  logic signed [DATA_W-1:0] a_sel, b_sel;
  logic signed [ACC_W-1:0]  mac_sum;
  logic [OUT_W-1:0]        elem;

  function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] != v[OUT_W-1];
  endfunction

  function automatic logic [OUT_W-1:0] fit_elem(input logic signed [ACC_W-1:0] v);
`ifdef MATMUL_SAT_EN
    if (out_of_range(v)) begin
      return v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
    return v[OUT_W-1:0];
  endfunction

  // Step bits are {i, j, k}; k toggles fastest.
  assign a_idx = {step_q[2], step_q[0]};
  assign b_idx = {step_q[0], step_q[1]};
  assign c_idx = step_q[2:1];
  assign a_sel = a_q[a_idx*DATA_W +: DATA_W];
  assign b_sel = b_q[b_idx*DATA_W +: DATA_W];
  assign elem  = fit_elem(mac_sum);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    accept  = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    elem_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CALC;
          step_d  = '0;
        end
      end
      ST_CALC: begin
        mac_en  = 1'b1;
        mac_clr = ~step_q[0];
        elem_wr = step_q[0];
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (a_sel),
    .b_i   (b_sel),
    .sum_o (mac_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        ovf_q <= 1'b0;
      end else if (elem_wr && out_of_range(mac_sum)) begin
        ovf_q <= 1'b1;
      end
      // The last element bypasses the shadow so c_out lands on the edge entering DONE.
      if (elem_wr && (step_q == 3'd7)) begin
        c_q <= {elem, shadow_q[2], shadow_q[1], shadow_q[0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a_in;
      b_q <= b_in;
    end
    if (elem_wr) begin
      shadow_q[c_idx] <= elem;
    end
  end

  assign c_out = c_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_matmul_2x2_seq.sv
// Self-checking bench for matmul_2x2_seq against an arithmetic reference model.
module tb_matmul_2x2_seq;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [4*DATA_W-1:0] a_in, b_in;
  logic [4*OUT_W-1:0]  c_out;
  logic                busy, done, ovf;

  int checks   = 0;
  int failures = 0;

  int               ma [4];
  int               mb [4];
  int               mc [4];
  bit               mov;
  logic [4*OUT_W-1:0] exp_c;
  logic [4*OUT_W-1:0] last_c;

  always #5 clk = ~clk;

  matmul_2x2_seq #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_out (c_out),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plain matrix product, then range handling of each 2-term sum.
  task automatic model;
    logic signed [OUT_W-1:0] w;
    int s;
    mov = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = ma[2*i] * mb[j] + ma[2*i+1] * mb[2+j];
        if (s > 32767 || s < -32768) mov = 1'b1;
`ifdef MATMUL_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        w = s[OUT_W-1:0];
        mc[2*i+j] = w;
      end
    end
    for (int e = 0; e < 4; e++) exp_c[e*OUT_W +: OUT_W] = mc[e][OUT_W-1:0];
  endtask

  task automatic load_ops;
    for (int e = 0; e < 4; e++) begin
      a_in[e*DATA_W +: DATA_W] = ma[e][DATA_W-1:0];
      b_in[e*DATA_W +: DATA_W] = mb[e][DATA_W-1:0];
    end
    model();
  endtask

  task automatic rand_ops;
    for (int e = 0; e < 4; e++) begin
      ma[e] = int'($urandom_range(0, 255)) - 128;
      mb[e] = int'($urandom_range(0, 255)) - 128;
    end
    load_ops();
  endtask

  task automatic run_and_check(input string name);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_accept: busy=%b expected=1", name, busy);
    end
    checks++;
    if (c_out !== last_c) begin
      failures++;
      $display("FAIL %s c_out_hold: c_out=%h expected=%h", name, c_out, last_c);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL %s latency: cycles=%0d expected=8", name, n);
    end
    checks++;
    if (c_out !== exp_c) begin
      failures++;
      $display("FAIL %s c_out: c_out=%h expected=%h", name, c_out, exp_c);
    end
    checks++;
    if (ovf !== mov) begin
      failures++;
      $display("FAIL %s ovf: ovf=%b expected=%b", name, ovf, mov);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b expected done=0 busy=0", name, done, busy);
    end
    last_c = exp_c;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || c_out !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b c_out=%h expected all 0", busy, done, ovf, c_out);
    end
    rst = 1'b1;
    last_c = '0;
    tick();
  endtask

  task automatic test_fixed;
    ma = '{1, 2, 3, 4};     mb = '{5, 6, 7, 8};     load_ops(); run_and_check("basic");
    ma = '{-3, 4, 2, -1};   mb = '{5, -2, 0, 7};    load_ops(); run_and_check("signed");
    ma = '{-128, -128, -128, -128}; mb = '{-128, -128, -128, -128};
    load_ops(); run_and_check("overflow");
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      rand_ops();
      run_and_check("random");
    end
  endtask

  task automatic test_restart_ignored;
    int cnt, first;
    rand_ops();
    start = 1'b1;
    tick();
    cnt = 0; first = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      start = (cyc == 3 || cyc == 6);
      if (start) begin
        a_in = $urandom;
        b_in = $urandom;
      end
      tick();
      if (done === 1'b1) begin
        cnt++;
        if (first == 0) first = cyc;
      end
    end
    start = 1'b0;
    checks++;
    if (cnt != 1 || first != 8) begin
      failures++;
      $display("FAIL restart_done: pulses=%0d first=%0d expected pulses=1 first=8", cnt, first);
    end
    checks++;
    if (c_out !== exp_c) begin
      failures++;
      $display("FAIL restart_c_out: c_out=%h expected=%h", c_out, exp_c);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_idle: busy=%b expected=0", busy);
    end
    last_c = exp_c;
  endtask

  task automatic test_reset_mid;
    int cnt;
    ma = '{-128, -128, -128, -128}; mb = '{-128, -128, -128, -128};
    load_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || c_out !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b ovf=%b c_out=%h expected all 0", busy, done, ovf, c_out);
    end
    tick();
    rst = 1'b1;
    last_c = '0;
    cnt = 0;
    for (int s = 0; s < 12; s++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL reset_no_done: pulses=%0d expected=0", cnt);
    end
    rand_ops();
    run_and_check("after_reset");
  endtask

  task automatic test_back_to_back;
    logic exp_done, exp_busy;
    rand_ops();
    start = 1'b1;
    tick();
    for (int t = 1; t <= 30; t++) begin
      tick();
      exp_done = (t % 10 == 8);
      exp_busy = (t % 10 != 9);
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL b2b_done t=%0d: done=%b expected=%b", t, done, exp_done);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL b2b_busy t=%0d: busy=%b expected=%b", t, busy, exp_busy);
      end
      if (exp_done) begin
        checks++;
        if (c_out !== exp_c || ovf !== mov) begin
          failures++;
          $display("FAIL b2b_result t=%0d: c_out=%h ovf=%b expected=%h ovf=%b", t, c_out, ovf, exp_c, mov);
        end
      end
    end
    start = 1'b0;
    for (int t = 0; t < 12; t++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: busy=%b expected=0", busy);
    end
    last_c = exp_c;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
